// File: rtl/cnt_ctrl.sv
// cnt_ctrl: run controller for the cnt counter.
// It takes the config over a handshake, issues prescaled enables and stops the counter on its end flag.
module cnt_ctrl #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [CNT_W-1:0]   cfg_target_i,
    input  logic [PRESC_W-1:0] cfg_presc_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               cnt_end_i,
    output logic               cnt_en_o,
    output logic [CNT_W-1:0]   cnt_target_o,
    output logic               busy_o,
    output logic               done_o
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   target_q;
    logic [PRESC_W-1:0] presc_q, presc_cnt, presc_next;
    logic               tick, cfg_fire, done_q;

    always_comb begin
        cfg_ready_o = (state == IDLE) || (state == DONE);
        cfg_fire    = cfg_valid_i && cfg_ready_o;
        busy_o      = (state == RUN) || (state == HOLD);
        tick        = presc_cnt == presc_q;
        cnt_en_o    = (state == RUN) && tick && !cnt_end_i;
        state_next  = state;
        presc_next  = presc_cnt;
        case (state)
            IDLE: if (start_i && !stop_i) begin
                state_next = RUN;
                presc_next = '0;
            end
            RUN: begin
                presc_next = tick ? '0 : presc_cnt + 1'b1;
                state_next = cnt_end_i ? DONE : stop_i ? HOLD : RUN;
            end
            // Resume keeps the prescaler phase, so no partial period is lost or repeated.
            HOLD: state_next = (start_i && !stop_i) ? RUN : HOLD;
            DONE: state_next = cfg_fire ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            target_q  <= '0;
            presc_q   <= '0;
            presc_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            presc_cnt <= presc_next;
            done_q    <= (state == RUN) && cnt_end_i;
            if (cfg_fire) begin
                target_q <= cfg_target_i;
                presc_q  <= cfg_presc_i;
            end
        end
    end

    assign cnt_target_o = target_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed bench for cnt_ctrl driving a small model of the downstream counter.
module tb_cnt_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [31:0] cfg_target = '0, cnt_target, cnt = '0;
    logic [15:0] cfg_presc = '0;
    logic        start = 1'b0, stop = 1'b0, cnt_end, cnt_en, busy, done;
    int          checks = 0, errors = 0;
    int          cyc, ens;
    logic [31:0] pat;

    always #5 clk = ~clk;

    cnt_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_target_i(cfg_target), .cfg_presc_i(cfg_presc), .start_i(start), .stop_i(stop),
        .cnt_end_i(cnt_end), .cnt_en_o(cnt_en), .cnt_target_o(cnt_target), .busy_o(busy), .done_o(done)
    );

    // Downstream counter: cleared only by reset, end flag purely from flops.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (cnt_en) cnt <= cnt + 1;
    assign cnt_end = cnt == cnt_target;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [31:0] t, input logic [15:0] p);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_target = t; cfg_presc = p;
        @(posedge clk) #1 cfg_valid = 1'b0;
    endtask

    task automatic go();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic watch(input int max, output int c, output logic [31:0] p);
        logic seen = 1'b0;
        c = 0; p = '0;
        while (!seen && c < max) begin
            @(negedge clk);
            p = {p[30:0], cnt_en};
            c++;
            seen = done;
        end
        check("watch_done", 32'(seen), 1);
    endtask

    initial begin
        reset();
        @(negedge clk);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_en", 32'(cnt_en), 0);
        check("rst_target", cnt_target, 0);

        // 1: presc 0, five consecutive enables then done
        cfg(5, 0);
        go();
        watch(40, cyc, pat);
        check("t1_pattern", pat, 32'h7C);
        check("t1_cnt", cnt, 5);
        check("t1_busy", 32'(busy), 0);
        @(negedge clk);
        check("t1_done_once", 32'(done), 0);
        check("t1_hold_cnt", cnt, 5);

        // target equal to current count: done with zero enables
        cfg(5, 0);
        go();
        watch(40, cyc, pat);
        check("eq_pattern", pat, 0);
        check("eq_cycles", 32'(cyc), 2);

        // 2: presc 2, one enable every third cycle
        reset();
        cfg(3, 2);
        go();
        watch(60, cyc, pat);
        check("t2_pattern", pat, 32'h124);
        check("t2_cnt", cnt, 3);

        // 3: pause at 4, hold, resume to 10
        reset();
        cfg(10, 0);
        go();
        for (int i = 0; i < 20 && !stop; i++) @(negedge clk) if (cnt == 3) stop = 1'b1;
        @(posedge clk) #1 stop = 1'b0;
        ens = 0;
        repeat (6) @(negedge clk) ens += int'(cnt_en);
        check("t3_hold_en", 32'(ens), 0);
        check("t3_hold_cnt", cnt, 4);
        check("t3_hold_busy", 32'(busy), 1);
        check("t3_hold_ready", 32'(cfg_ready), 0);
        go();
        watch(40, cyc, pat);
        check("t3_pattern", pat, 32'hFC);
        check("t3_cnt", cnt, 10);

        // resume keeps prescaler phase
        reset();
        cfg(2, 3);
        go();
        @(negedge clk);
        @(negedge clk) stop = 1'b1;
        @(posedge clk) #1 stop = 1'b0;
        repeat (3) @(negedge clk);
        go();
        watch(40, cyc, pat);
        check("phase_pattern", pat, 32'h44);

        // 4: stop in the cycle the end flag rises
        reset();
        cfg(2, 0);
        go();
        repeat (3) @(negedge clk);
        check("t4_end", 32'(cnt_end), 1);
        stop = 1'b1;
        @(posedge clk) #1 stop = 1'b0;
        @(negedge clk);
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        @(negedge clk);
        check("t4_done_once", 32'(done), 0);

        // 5: config refused in RUN/HOLD, accepted in DONE
        reset();
        cfg(4, 0);
        go();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_target = 99;
        check("t5_run_ready", 32'(cfg_ready), 0);
        @(negedge clk) stop = 1'b1;
        @(posedge clk) #1 stop = 1'b0;
        @(negedge clk);
        check("t5_hold_ready", 32'(cfg_ready), 0);
        check("t5_hold_target", cnt_target, 4);
        cfg_valid = 1'b0;
        go();
        watch(40, cyc, pat);
        check("t5_cnt", cnt, 4);
        go();
        @(negedge clk);
        check("t5_done_start_ignored", 32'(busy), 0);
        check("t5_done_ready", 32'(cfg_ready), 1);
        cfg(7, 0);
        @(negedge clk);
        check("t5_new_target", cnt_target, 7);
        go();
        @(negedge clk);
        check("t5_idle_start", 32'(busy), 1);

        // 6: asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_busy", 32'(busy), 0);
        check("t6_async_en", 32'(cnt_en), 0);
        check("t6_async_target", cnt_target, 0);
        @(negedge clk) rst_n = 1'b1;
        ens = 0;
        repeat (3) @(negedge clk) ens += int'(done);
        check("t6_no_done", 32'(ens), 0);
        check("t6_ready", 32'(cfg_ready), 1);
        check("t6_target", cnt_target, 0);
        check("t6_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
